// File: rtl/sprite_anim_ctrl_if.sv
// Control, position, scan and ROM-address signals between game logic and the
// sprite animation controller.
interface sprite_anim_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              frame_tick;
  logic              move_req;
  logic              attack_req;
  logic              hit_req;
  logic              facing_left;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic [ADDR_W-1:0] rom_address;
  logic              sprite_on;
  logic [1:0]        anim_state;
  logic              busy;
  logic              attack_active;

  modport master (
    output frame_tick, move_req, attack_req, hit_req, facing_left,
    output pos_x, pos_y, DrawX, DrawY, blank,
    input  rom_address, sprite_on, anim_state, busy, attack_active
  );

  modport slave (
    input  frame_tick, move_req, attack_req, hit_req, facing_left,
    input  pos_x, pos_y, DrawX, DrawY, blank,
    output rom_address, sprite_on, anim_state, busy, attack_active
  );
endinterface

// File: rtl/sprite_anim_ctrl.sv
// Per-fighter animation sequencer (idle/walk/attack/hit) and sprite-ROM address
// generator for a frame-stacked sprite ROM.
module sprite_anim_ctrl #(
  parameter int unsigned SPR_W       = 64,
  parameter int unsigned SPR_H       = 64,
  parameter int unsigned FRAMES_WALK = 4,
  parameter int unsigned FRAMES_ATK  = 3,
  parameter int unsigned ATK_HIT_FRM = 1,
  parameter int unsigned HOLD        = 6,
  parameter int unsigned ADDR_W      = 16
) (
  input logic              vga_clk,
  input logic              reset,
  sprite_anim_ctrl_if.slave bus
);

  localparam int unsigned LX_W  = $clog2(SPR_W);
  localparam int unsigned LY_W  = $clog2(SPR_H);
  localparam int unsigned CNT_W = $clog2(2 * HOLD) + 1;
  localparam int unsigned FI_W  = $clog2(FRAMES_WALK + FRAMES_ATK) + 1;
  localparam int unsigned FRM_W = $clog2(FRAMES_WALK + FRAMES_ATK + 2) + 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWalk   = 2'd1,
    StAttack = 2'd2,
    StHit    = 2'd3
  } state_t;

  state_t            state_q, state_d, nxt;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic [FI_W-1:0]   fidx_q, fidx_d;
  logic              pend_atk_q, pend_atk_d, pend_hit_q, pend_hit_d;
  logic              eff_atk, eff_hit;
  logic [FRM_W-1:0]  frame_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              busy_q, atk_act_q;
  logic [ADDR_W-1:0] addr_q;
  logic              on_q;

  // Window test and local sprite coordinates for the current scan position
  logic [10:0]     dx, dy;
  logic            in_win;
  logic [LX_W-1:0] lx;
  logic [LY_W-1:0] ly;

  // Next-state: requests are sticky until the next tick; all sequencing happens on a tick
  always_comb begin
    state_d    = state_q;
    nxt        = state_q;
    hold_d     = hold_q;
    fidx_d     = fidx_q;
    eff_atk    = pend_atk_q | bus.attack_req;
    eff_hit    = pend_hit_q | bus.hit_req;
    pend_atk_d = eff_atk;
    pend_hit_d = eff_hit;
    if (bus.frame_tick) begin
      pend_atk_d = 1'b0;
      pend_hit_d = 1'b0;
      unique case (state_q)
        StIdle, StWalk: begin
          if (eff_hit)           nxt = StHit;
          else if (eff_atk)      nxt = StAttack;
          else if (bus.move_req) nxt = StWalk;
          else                   nxt = StIdle;
          if (nxt != state_q) begin
            state_d = nxt;
            hold_d  = '0;
            fidx_d  = '0;
          end else if (state_q == StWalk) begin
            if (hold_q == CNT_W'(HOLD - 1)) begin
              hold_d = '0;
              fidx_d = (fidx_q == FI_W'(FRAMES_WALK - 1)) ? '0 : fidx_q + 1'b1;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
        StAttack: begin
          if (eff_hit) begin
            state_d = StHit;
            hold_d  = '0;
            fidx_d  = '0;
          end else if (hold_q == CNT_W'(HOLD - 1)) begin
            hold_d = '0;
            if (fidx_q == FI_W'(FRAMES_ATK - 1)) begin
              state_d = bus.move_req ? StWalk : StIdle;
              fidx_d  = '0;
            end else begin
              fidx_d = fidx_q + 1'b1;
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        StHit: begin
          // A fresh hit restarts the stagger; pending attacks are simply discarded
          if (eff_hit) begin
            hold_d = '0;
          end else if (hold_q == CNT_W'(2 * HOLD - 1)) begin
            state_d = StIdle;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Frame number of the next state, converted to its ROM base address
  always_comb begin
    frame_d = '0;
    unique case (state_d)
      StIdle:   frame_d = '0;
      StWalk:   frame_d = FRM_W'(1) + FRM_W'(fidx_d);
      StAttack: frame_d = FRM_W'(1 + FRAMES_WALK) + FRM_W'(fidx_d);
      StHit:    frame_d = FRM_W'(1 + FRAMES_WALK + FRAMES_ATK);
    endcase
    base_d = ADDR_W'(frame_d) << (LX_W + LY_W);
  end

  // Sequencer state; base only moves on a tick so a displayed frame never tears
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      fidx_q     <= '0;
      pend_atk_q <= 1'b0;
      pend_hit_q <= 1'b0;
      base_q     <= '0;
      busy_q     <= 1'b0;
      atk_act_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      fidx_q     <= fidx_d;
      pend_atk_q <= pend_atk_d;
      pend_hit_q <= pend_hit_d;
      if (bus.frame_tick) base_q <= base_d;
      busy_q     <= (state_d == StAttack) || (state_d == StHit);
      atk_act_q  <= (state_d == StAttack) && (fidx_d == FI_W'(ATK_HIT_FRM));
    end
  end

  // 11-bit compares so a window hanging off the right/bottom edge clips instead of wrapping
  always_comb begin
    dx     = {1'b0, bus.DrawX} - {1'b0, bus.pos_x};
    dy     = {1'b0, bus.DrawY} - {1'b0, bus.pos_y};
    in_win = bus.blank
          && ({1'b0, bus.DrawX} >= {1'b0, bus.pos_x})
          && ({1'b0, bus.DrawX} <  {1'b0, bus.pos_x} + 11'(SPR_W))
          && ({1'b0, bus.DrawY} >= {1'b0, bus.pos_y})
          && ({1'b0, bus.DrawY} <  {1'b0, bus.pos_y} + 11'(SPR_H));
    lx     = bus.facing_left ? LX_W'(SPR_W - 1) - dx[LX_W-1:0] : dx[LX_W-1:0];
    ly     = dy[LY_W-1:0];
  end

  // Registered ROM address; the ROM itself samples on the falling edge
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      addr_q <= '0;
      on_q   <= 1'b0;
    end else begin
      addr_q <= in_win ? base_q + ADDR_W'({ly, lx}) : '0;
      on_q   <= in_win;
    end
  end

  assign bus.rom_address   = addr_q;
  assign bus.sprite_on     = on_q;
  assign bus.anim_state    = state_q;
  assign bus.busy          = busy_q;
  assign bus.attack_active = atk_act_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed self-checking bench for sprite_anim_ctrl.
module tb_sprite_anim_ctrl;

  logic vga_clk = 1'b0;
  logic reset   = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  sprite_anim_ctrl_if #(.ADDR_W(16)) bus ();

  sprite_anim_ctrl #(
    .SPR_W(64), .SPR_H(64), .FRAMES_WALK(4), .FRAMES_ATK(3),
    .ATK_HIT_FRM(1), .HOLD(6), .ADDR_W(16)
  ) dut (
    .vga_clk (vga_clk),
    .reset   (reset),
    .bus     (bus.slave)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame_tick cycle, optionally carrying request pulses in the same cycle
  task automatic tick(input bit atk, input bit hit);
    @(negedge vga_clk);
    bus.frame_tick = 1'b1;
    bus.attack_req = atk;
    bus.hit_req    = hit;
    @(negedge vga_clk);
    bus.frame_tick = 1'b0;
    bus.attack_req = 1'b0;
    bus.hit_req    = 1'b0;
  endtask

  // Present a scan position; outputs are valid one cycle later
  task automatic scan(input int x, input int y);
    @(negedge vga_clk);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    @(negedge vga_clk);
  endtask

  initial begin
    bus.frame_tick  = 1'b0;
    bus.move_req    = 1'b0;
    bus.attack_req  = 1'b0;
    bus.hit_req     = 1'b0;
    bus.facing_left = 1'b0;
    bus.pos_x       = 10'd100;
    bus.pos_y       = 10'd50;
    bus.DrawX       = 10'd0;
    bus.DrawY       = 10'd0;
    bus.blank       = 1'b1;
    repeat (3) @(negedge vga_clk);
    reset = 1'b0;
    @(negedge vga_clk);
    check("rst_state", int'(bus.anim_state), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_atk", int'(bus.attack_active), 0);
    check("rst_addr", int'(bus.rom_address), 0);
    check("rst_on", int'(bus.sprite_on), 0);

    // Idle scan of window corners and just outside
    repeat (3) tick(0, 0);
    check("idle_state", int'(bus.anim_state), 0);
    scan(100, 50);
    check("idle_tl_on", int'(bus.sprite_on), 1);
    check("idle_tl_addr", int'(bus.rom_address), 0);
    scan(164, 50);
    check("idle_right_on", int'(bus.sprite_on), 0);
    check("idle_right_addr", int'(bus.rom_address), 0);
    scan(163, 113);
    check("idle_br_on", int'(bus.sprite_on), 1);
    check("idle_br_addr", int'(bus.rom_address), 4095);
    scan(100, 114);
    check("idle_below_on", int'(bus.sprite_on), 0);

    // Walk: frames 1,2,3,4,1 each held for 6 ticks
    bus.move_req = 1'b1;
    tick(0, 0);
    check("walk_state", int'(bus.anim_state), 1);
    scan(100, 50);
    check("walk_k0_addr", int'(bus.rom_address), 4096);
    for (int k = 1; k < 30; k++) begin
      tick(0, 0);
      if ((k % 6 == 0) || (k % 6 == 5)) begin
        scan(100, 50);
        check($sformatf("walk_k%0d_addr", k), int'(bus.rom_address),
              4096 * (1 + (k / 6) % 4));
      end
    end
    check("walk_end_state", int'(bus.anim_state), 1);

    // Attack requested between ticks, entered on the next tick
    @(negedge vga_clk);
    bus.attack_req = 1'b1;
    @(negedge vga_clk);
    bus.attack_req = 1'b0;
    check("atk_wait_state", int'(bus.anim_state), 1);
    tick(0, 0);
    check("atk_state", int'(bus.anim_state), 2);
    check("atk_busy", int'(bus.busy), 1);
    check("atk_k0_active", int'(bus.attack_active), 0);
    scan(100, 50);
    check("atk_k0_addr", int'(bus.rom_address), 5 * 4096);
    for (int k = 1; k < 18; k++) begin
      tick(0, 0);
      check($sformatf("atk_k%0d_active", k), int'(bus.attack_active),
            ((k >= 6) && (k <= 11)) ? 1 : 0);
      if (k == 17) check("atk_k17_state", int'(bus.anim_state), 2);
      if (k == 12) begin
        scan(100, 50);
        check("atk_k12_addr", int'(bus.rom_address), 7 * 4096);
      end
    end
    tick(0, 0);
    check("atk_done_state", int'(bus.anim_state), 1);
    check("atk_done_busy", int'(bus.busy), 0);
    scan(100, 50);
    check("atk_done_addr", int'(bus.rom_address), 4096);

    // Hit beats attack on the same tick; a second hit restarts the stagger
    bus.move_req = 1'b0;
    tick(1, 1);
    check("hit_state", int'(bus.anim_state), 3);
    check("hit_busy", int'(bus.busy), 1);
    scan(100, 50);
    check("hit_addr", int'(bus.rom_address), 8 * 4096);
    repeat (4) tick(0, 0);
    tick(0, 1);
    for (int k = 1; k < 12; k++) tick(0, 0);
    check("hit_k11_state", int'(bus.anim_state), 3);
    tick(0, 0);
    check("hit_end_state", int'(bus.anim_state), 0);
    check("hit_end_busy", int'(bus.busy), 0);

    // Mirrored fetch in walk frame 1
    bus.move_req    = 1'b1;
    bus.facing_left = 1'b1;
    bus.pos_x       = 10'd0;
    bus.pos_y       = 10'd0;
    tick(0, 0);
    scan(0, 1);
    check("mirror_left_addr", int'(bus.rom_address), 4096 + 64 + 63);
    scan(63, 1);
    check("mirror_right_addr", int'(bus.rom_address), 4096 + 64);
    scan(64, 1);
    check("mirror_out_on", int'(bus.sprite_on), 0);
    bus.blank = 1'b0;
    scan(0, 1);
    check("blank_on", int'(bus.sprite_on), 0);
    check("blank_addr", int'(bus.rom_address), 0);
    bus.blank = 1'b1;

    // Window past x=1023 must not wrap onto the left edge
    bus.pos_x = 10'd1000;
    scan(20, 0);
    check("nowrap_on", int'(bus.sprite_on), 0);
    bus.pos_x = 10'd0;

    // Reset during attack frame 2
    @(negedge vga_clk);
    bus.attack_req = 1'b1;
    @(negedge vga_clk);
    bus.attack_req = 1'b0;
    tick(0, 0);
    repeat (12) tick(0, 0);
    scan(0, 1);
    check("pre_rst_busy", int'(bus.busy), 1);
    check("pre_rst_addr", int'(bus.rom_address), 7 * 4096 + 64 + 63);
    reset = 1'b1;
    @(negedge vga_clk);
    check("mid_rst_state", int'(bus.anim_state), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_atk", int'(bus.attack_active), 0);
    check("mid_rst_addr", int'(bus.rom_address), 0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
